// File: rtl/azadi_prog_uart_loader.sv
// Boot-programming UART loader: conditions the prog/rx pads, receives 8N1 bytes during a
// programming session and issues little-endian 32-bit instruction-memory writes.
//
// state   | meaning
// IDLE    | line idle, waiting for rx low as a start-bit candidate
// START   | counting to mid start bit; rx high there means it was a glitch
// DATA    | sampling 8 data bits LSB-first, one per bit period
// STOP    | waiting for mid stop bit; high = valid byte, low = frame error
// ERRWAIT | after a frame error, waiting for the line to return high
module azadi_prog_uart_loader #(
  parameter int unsigned ADDR_W      = 12,
  parameter logic [31:0] EOF_WORD    = 32'h0000_0FFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_i,
  input  logic              rx_i,
  input  logic [15:0]       clks_per_bit_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              frame_err_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, ERRWAIT} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] prog_sync, rx_sync;
  logic        prog_s, rx_s, prog_d;
  logic        prog_rise, prog_fall, abort;
  logic [15:0] cpb, cpb_q, cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic [23:0] word_q;
  logic [1:0]  idx;
  logic [31:0] full_word;
  logic        start_det, bit_load, cnt_dec, shift_en, byte_done, frame_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prog_sync <= '0;
      rx_sync   <= '1;
      prog_d    <= 1'b0;
    end else begin
      prog_sync <= {prog_sync[SYNC_STAGES-2:0], prog_i};
      rx_sync   <= {rx_sync[SYNC_STAGES-2:0], rx_i};
      prog_d    <= prog_s;
    end
  end

  assign prog_s    = prog_sync[SYNC_STAGES-1];
  assign rx_s      = rx_sync[SYNC_STAGES-1];
  assign prog_rise = prog_s & ~prog_d;
  assign prog_fall = ~prog_s & prog_d;
  assign abort     = busy_o & prog_fall;
  // Very short bit periods would leave no room for the mid-bit sample point.
  assign cpb       = (clks_per_bit_i < 16'd4) ? 16'd4 : clks_per_bit_i;
  assign full_word = {shift_q, word_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    bit_load  = 1'b0;
    cnt_dec   = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    frame_set = 1'b0;
    if (!busy_o || abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (!rx_s) begin
          start_det = 1'b1;
          state_d   = START;
        end
        START: if (cnt == 16'd0) begin
          if (!rx_s) begin
            bit_load = 1'b1;
            state_d  = DATA;
          end else begin
            state_d = IDLE;
          end
        end else cnt_dec = 1'b1;
        DATA: if (cnt == 16'd0) begin
          shift_en = 1'b1;
          bit_load = 1'b1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end else cnt_dec = 1'b1;
        STOP: if (cnt == 16'd0) begin
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = ERRWAIT;
          end
        end else cnt_dec = 1'b1;
        ERRWAIT: if (rx_s) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt         <= '0;
      cpb_q       <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      idx         <= '0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      we_o <= 1'b0;
      if (start_det) begin
        cpb_q   <= cpb;
        cnt     <= (cpb >> 1) - 16'd1;
        bit_cnt <= '0;
      end else if (bit_load) begin
        cnt <= cpb_q - 16'd1;
      end else if (cnt_dec) begin
        cnt <= cnt - 16'd1;
      end
      if (shift_en) begin
        shift_q <= {rx_s, shift_q[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (we_o) addr_o <= addr_o + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (prog_rise && !busy_o) begin
        busy_o      <= 1'b1;
        done_o      <= 1'b0;
        frame_err_o <= 1'b0;
        addr_o      <= '0;
        idx         <= '0;
      end else if (abort) begin
        busy_o <= 1'b0;
        idx    <= '0;
      end else begin
        if (frame_set) frame_err_o <= 1'b1;
        if (byte_done) begin
          case (idx)
            2'd0:    word_q[7:0]   <= shift_q;
            2'd1:    word_q[15:8]  <= shift_q;
            2'd2:    word_q[23:16] <= shift_q;
            default: ;
          endcase
          if (idx == 2'd3) begin
            idx <= '0;
            // The end-of-image word closes the session instead of being written.
            if (full_word == EOF_WORD) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              we_o    <= 1'b1;
              wdata_o <= full_word;
            end
          end else begin
            idx <= idx + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_azadi_prog_uart_loader.sv
// Bench for azadi_prog_uart_loader: random UART traffic against a byte/word-level session model.
// A second instance with ADDR_W=2 exercises address wrap.
module tb_azadi_prog_uart_loader;
  localparam logic [31:0] EOF = 32'h0000_0FFF;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        prog_i = 1'b0;
  logic        rx_i = 1'b1;
  logic [15:0] clks_per_bit_i = 16'd16;

  logic        we1, busy1, done1, ferr1;
  logic [11:0] addr1;
  logic [31:0] wdata1;
  logic        we2, busy2, done2, ferr2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;

  azadi_prog_uart_loader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .prog_i(prog_i), .rx_i(rx_i),
    .clks_per_bit_i(clks_per_bit_i), .we_o(we1), .addr_o(addr1), .wdata_o(wdata1),
    .busy_o(busy1), .done_o(done1), .frame_err_o(ferr1)
  );

  azadi_prog_uart_loader #(.ADDR_W(2)) dut_w2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .prog_i(prog_i), .rx_i(rx_i),
    .clks_per_bit_i(clks_per_bit_i), .we_o(we2), .addr_o(addr2), .wdata_o(wdata2),
    .busy_o(busy2), .done_o(done2), .frame_err_o(ferr2)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  logic [43:0] cap1[$], exp1[$];
  logic [33:0] cap2[$], exp2[$];
  logic [7:0]  mbytes[$];
  bit          m_busy, m_done, m_ferr;
  int          m_addr;

  always @(negedge clk_i) begin
    if (we1) cap1.push_back({addr1, wdata1});
    if (we2) cap2.push_back({addr2, wdata2});
  end

  task automatic clear_sb();
    cap1.delete(); exp1.delete(); cap2.delete(); exp2.delete();
  endtask

  // Session-level reference: good bytes collect into little-endian words while busy.
  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [31:0] w;
    if (!m_busy) return;
    if (!good) begin
      m_ferr = 1'b1;
      return;
    end
    mbytes.push_back(b);
    if (mbytes.size() == 4) begin
      w = {mbytes[3], mbytes[2], mbytes[1], mbytes[0]};
      mbytes.delete();
      if (w == EOF) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end else begin
        exp1.push_back({m_addr[11:0], w});
        exp2.push_back({m_addr[1:0], w});
        m_addr = m_addr + 1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    int eff;
    eff = (clks_per_bit_i < 16'd4) ? 4 : int'(clks_per_bit_i);
    @(negedge clk_i);
    rx_i = 1'b0;
    repeat (eff) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (eff) @(negedge clk_i);
    end
    rx_i = good;
    repeat (eff) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (4) @(negedge clk_i);
    model_byte(b, good);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic session_start();
    @(negedge clk_i);
    if (!prog_i) begin
      prog_i = 1'b1;
      if (!m_busy) begin
        m_busy = 1'b1; m_done = 1'b0; m_ferr = 1'b0; m_addr = 0;
        mbytes.delete();
      end
    end
    repeat (6) @(negedge clk_i);
  endtask

  task automatic session_stop();
    @(negedge clk_i);
    if (prog_i) begin
      prog_i = 1'b0;
      if (m_busy) begin
        m_busy = 1'b0;
        mbytes.delete();
      end
    end
    repeat (6) @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    vectors++;
    if ({we1, addr1, wdata1, busy1, done1, ferr1} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold_dut: got we=%b addr=%h wdata=%h busy=%b done=%b ferr=%b required all 0",
               we1, addr1, wdata1, busy1, done1, ferr1);
    end
    vectors++;
    if ({we2, addr2, wdata2, busy2, done2, ferr2} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold_dut_w2: got nonzero outputs, required all 0");
    end
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    vectors++;
    if ({we1, addr1, wdata1, busy1, done1, ferr1} !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got we=%b addr=%h wdata=%h busy=%b done=%b ferr=%b required all 0",
               we1, addr1, wdata1, busy1, done1, ferr1);
    end
  endtask

  task automatic test_basic_words();
    clks_per_bit_i = 16'd16;
    clear_sb();
    session_start();
    vectors++;
    if (busy1 !== m_busy) begin
      miscompares++;
      $display("FAIL basic_busy: got %b required %b", busy1, m_busy);
    end
    send_word(32'h1234_5678);
    vectors++;
    if (cap1.size() != 1 || cap1[0] !== {12'd0, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL basic_first_word: got %0d writes, first %h required 1 write %h",
               cap1.size(), (cap1.size() > 0) ? cap1[0] : 44'h0, {12'd0, 32'h1234_5678});
    end
    for (int k = 0; k < 2; k++) send_word($urandom);
    send_word(EOF);
    vectors++;
    if (cap1.size() != exp1.size()) begin
      miscompares++;
      $display("FAIL basic_write_count: got %0d required %0d", cap1.size(), exp1.size());
    end
    for (int i = 0; i < cap1.size() && i < exp1.size(); i++) begin
      vectors++;
      if (cap1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL basic_write[%0d]: got %h required %h", i, cap1[i], exp1[i]);
      end
    end
    vectors++;
    if ({done1, busy1} !== {m_done, m_busy} || addr1 !== m_addr[11:0]) begin
      miscompares++;
      $display("FAIL basic_eof: got done=%b busy=%b addr=%h required done=%b busy=%b addr=%h",
               done1, busy1, addr1, m_done, m_busy, m_addr[11:0]);
    end
    vectors++;
    if (exp1.size() > 0 && wdata1 !== exp1[exp1.size()-1][31:0]) begin
      miscompares++;
      $display("FAIL basic_wdata_hold: got %h required %h", wdata1, exp1[exp1.size()-1][31:0]);
    end
  endtask

  task automatic test_frame_err();
    int pos;
    clks_per_bit_i = 16'($urandom_range(4, 12));
    session_stop();
    session_start();
    clear_sb();
    vectors++;
    if ({done1, ferr1, busy1} !== {m_done, m_ferr, m_busy}) begin
      miscompares++;
      $display("FAIL ferr_session_clear: got done=%b ferr=%b busy=%b required %b %b %b",
               done1, ferr1, busy1, m_done, m_ferr, m_busy);
    end
    pos = $urandom_range(0, 3);
    for (int i = 0; i < 4; i++) begin
      if (i == pos) send_byte(8'($urandom), 1'b0);
      send_byte(8'($urandom), 1'b1);
    end
    vectors++;
    if (ferr1 !== m_ferr) begin
      miscompares++;
      $display("FAIL ferr_sticky: got %b required %b", ferr1, m_ferr);
    end
    vectors++;
    if (cap1.size() != exp1.size()) begin
      miscompares++;
      $display("FAIL ferr_write_count: got %0d required %0d", cap1.size(), exp1.size());
    end
    for (int i = 0; i < cap1.size() && i < exp1.size(); i++) begin
      vectors++;
      if (cap1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL ferr_write[%0d]: got %h required %h", i, cap1[i], exp1[i]);
      end
    end
  endtask

  task automatic test_abort();
    clks_per_bit_i = 16'd16;
    session_stop();
    session_start();
    clear_sb();
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    session_stop();
    vectors++;
    if (busy1 !== m_busy || cap1.size() != 0) begin
      miscompares++;
      $display("FAIL abort_state: got busy=%b writes=%0d required busy=%b writes=0",
               busy1, cap1.size(), m_busy);
    end
    session_start();
    send_word($urandom);
    vectors++;
    if (cap1.size() != exp1.size()) begin
      miscompares++;
      $display("FAIL abort_write_count: got %0d required %0d", cap1.size(), exp1.size());
    end
    for (int i = 0; i < cap1.size() && i < exp1.size(); i++) begin
      vectors++;
      if (cap1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL abort_write[%0d]: got %h required %h", i, cap1[i], exp1[i]);
      end
    end
  endtask

  task automatic test_glitch_and_min_cpb();
    clks_per_bit_i = 16'd16;
    session_stop();
    session_start();
    clear_sb();
    @(negedge clk_i);
    rx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (40) @(negedge clk_i);
    vectors++;
    if (cap1.size() != 0 || ferr1 !== 1'b0 || busy1 !== m_busy) begin
      miscompares++;
      $display("FAIL glitch_ignored: got writes=%0d ferr=%b busy=%b required 0 0 %b",
               cap1.size(), ferr1, busy1, m_busy);
    end
    send_word($urandom);
    clks_per_bit_i = 16'($urandom_range(0, 1));
    send_word($urandom);
    send_word($urandom);
    vectors++;
    if (cap1.size() != exp1.size()) begin
      miscompares++;
      $display("FAIL glitch_write_count: got %0d required %0d", cap1.size(), exp1.size());
    end
    for (int i = 0; i < cap1.size() && i < exp1.size(); i++) begin
      vectors++;
      if (cap1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL glitch_write[%0d]: got %h required %h", i, cap1[i], exp1[i]);
      end
    end
  endtask

  task automatic test_not_busy();
    clks_per_bit_i = 16'($urandom_range(4, 10));
    session_stop();
    clear_sb();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    vectors++;
    if (busy1 !== m_busy || cap1.size() != 0) begin
      miscompares++;
      $display("FAIL idle_bytes: got busy=%b writes=%0d required busy=%b writes=0",
               busy1, cap1.size(), m_busy);
    end
    session_start();
    send_word($urandom);
    vectors++;
    if (cap1.size() != exp1.size()) begin
      miscompares++;
      $display("FAIL idle_write_count: got %0d required %0d", cap1.size(), exp1.size());
    end
    for (int i = 0; i < cap1.size() && i < exp1.size(); i++) begin
      vectors++;
      if (cap1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL idle_write[%0d]: got %h required %h", i, cap1[i], exp1[i]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    clks_per_bit_i = 16'($urandom_range(0, 6));
    session_stop();
    session_start();
    clear_sb();
    for (int k = 0; k < 5; k++) send_word($urandom);
    vectors++;
    if (cap2.size() != exp2.size()) begin
      miscompares++;
      $display("FAIL wrap_write_count: got %0d required %0d", cap2.size(), exp2.size());
    end
    for (int i = 0; i < cap2.size() && i < exp2.size(); i++) begin
      vectors++;
      if (cap2[i] !== exp2[i]) begin
        miscompares++;
        $display("FAIL wrap_write[%0d]: got %h required %h", i, cap2[i], exp2[i]);
      end
    end
    vectors++;
    if (addr2 !== m_addr[1:0]) begin
      miscompares++;
      $display("FAIL wrap_addr_final: got %h required %h", addr2, m_addr[1:0]);
    end
  endtask

  task automatic test_reset_mid_byte();
    clks_per_bit_i = 16'd8;
    session_stop();
    session_start();
    clear_sb();
    send_word($urandom);
    send_byte(8'($urandom), 1'b0);
    @(negedge clk_i);
    rx_i = 1'b0;
    repeat (20) @(negedge clk_i);
    vectors++;
    if ({busy1, ferr1} !== {m_busy, m_ferr} || addr1 !== m_addr[11:0]) begin
      miscompares++;
      $display("FAIL pre_reset_state: got busy=%b ferr=%b addr=%h required %b %b %h",
               busy1, ferr1, addr1, m_busy, m_ferr, m_addr[11:0]);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({we1, addr1, wdata1, busy1, done1, ferr1} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_byte: got we=%b addr=%h wdata=%h busy=%b done=%b ferr=%b required all 0",
               we1, addr1, wdata1, busy1, done1, ferr1);
    end
    vectors++;
    if ({we2, addr2, wdata2, busy2, done2, ferr2} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_byte_w2: got nonzero outputs, required all 0");
    end
    prog_i = 1'b0;
    rx_i   = 1'b1;
    m_busy = 1'b0; m_done = 1'b0; m_ferr = 1'b0; m_addr = 0;
    mbytes.delete();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_basic_words();
    test_frame_err();
    test_abort();
    test_glitch_and_min_cpb();
    test_not_busy();
    test_addr_wrap();
    test_reset_mid_byte();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
